// File: rtl/axi_lite_pkg.sv
// Shared constants and state encodings for the AXI-Lite slave register file.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_AW,
        W_EXEC,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Byte-strobed register array: one write port, one combinational read port
// and a flat image of every register for fabric logic.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                NUM_REGS  = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000,
    localparam int               IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       we,
    input  logic [IDX_W-1:0]           widx,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [STRB_W-1:0]          wstrb,
    input  logic [IDX_W-1:0]           ridx,
    output logic [DATA_W-1:0]          rdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_out
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= RESET_VAL;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    regs[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads see the pre-write contents, so a read colliding with a write gets the old value.
    assign rdata = regs[ridx];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[k*DATA_W +: DATA_W] = regs[k];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite slave exposing NUM_REGS 32-bit registers; independent write and
// read handshake FSMs around a byte-strobed register file.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int                NUM_REGS  = 8,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [STRB_W-1:0]          wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_out
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    w_state_t          w_state, w_state_next;
    r_state_t          r_state, r_state_next;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_in_range, ar_in_range, reg_we;
    logic [DATA_W-1:0] reg_rdata;

    assign aw_in_range = (aw_addr_q < ADDR_LIMIT);
    assign ar_in_range = (araddr < ADDR_LIMIT);
    assign reg_we      = (w_state == W_EXEC) && aw_in_range;

    axi_lite_regfile #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .aclk     (aclk),
        .areset   (areset),
        .we       (reg_we),
        .widx     (aw_addr_q[IDX_W+1:2]),
        .wdata    (wdata_q),
        .wstrb    (wstrb_q),
        .ridx     (araddr[IDX_W+1:2]),
        .rdata    (reg_rdata),
        .regs_out (regs_out)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    // Readies and valids are pure decodes of the registered state.
    always_comb begin
        w_state_next = w_state;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) w_state_next = W_EXEC;
                else if (awvalid)      w_state_next = W_WAIT_W;
                else if (wvalid)       w_state_next = W_WAIT_AW;
            end
            W_WAIT_W: begin
                wready = 1'b1;
                if (wvalid) w_state_next = W_EXEC;
            end
            W_WAIT_AW: begin
                awready = 1'b1;
                if (awvalid) w_state_next = W_EXEC;
            end
            W_EXEC: w_state_next = W_RESP;
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        arready      = (r_state == R_IDLE);
        rvalid       = (r_state == R_DATA);
        if (r_state == R_IDLE && arvalid)     r_state_next = R_DATA;
        else if (r_state == R_DATA && rready) r_state_next = R_IDLE;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp     <= RESP_OKAY;
        end else begin
            if (awready && awvalid) aw_addr_q <= awaddr;
            if (wready && wvalid) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (w_state == W_EXEC) bresp <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (r_state == R_IDLE && arvalid) begin
            rdata <= ar_in_range ? reg_rdata : '0;
            rresp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (NUM_REGS=8).
module tb_axi_lite_slave_regs;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 32;

    logic                   aclk, areset;
    logic [ADDR_W-1:0]      awaddr, araddr;
    logic                   awvalid, awready, wvalid, wready;
    logic [31:0]            wdata, rdata;
    logic [3:0]             wstrb;
    logic [1:0]             bresp, rresp;
    logic                   bvalid, bready, arvalid, arready, rvalid, rready;
    logic [NUM_REGS*32-1:0] regs_out;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_regs [NUM_REGS];
    logic [31:0] rd_data;
    logic [1:0]  rd_resp, wr_resp;

    axi_lite_slave_regs #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .regs_out (regs_out)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkRegs(input string tag);
        for (int k = 0; k < NUM_REGS; k++) begin
            checkOutput($sformatf("%s_reg%0d", tag, k), regs_out[k*32 +: 32], exp_regs[k]);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int cycles  = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && cycles < 20) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done  = 1;
            tick();
            cycles++;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        if (!(aw_done && w_done)) checkOutput("write_handshake_timeout", 32'd0, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        cycles = 0;
        while (!bvalid && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!bvalid) checkOutput("bvalid_timeout", 32'd0, 32'd1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic applyRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cycles = 0;
        araddr = addr;
        arvalid = 1'b1;
        while (!arready && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!arready) checkOutput("arready_timeout", 32'd0, 32'd1);
        tick();
        arvalid = 1'b0;
        checkOutput("rvalid_one_edge_after_ar", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 32'h0;

        // Reset state while held in reset.
        #12;
        checkOutput("rst_awready", 32'(awready), 32'd1);
        checkOutput("rst_wready",  32'(wready),  32'd1);
        checkOutput("rst_arready", 32'(arready), 32'd1);
        checkOutput("rst_bvalid",  32'(bvalid),  32'd0);
        checkOutput("rst_rvalid",  32'(rvalid),  32'd0);
        checkOutput("rst_bresp",   32'(bresp),   32'd0);
        checkOutput("rst_rresp",   32'(rresp),   32'd0);
        checkOutput("rst_rdata",   rdata,        32'd0);
        checkRegs("rst");
        @(negedge aclk);
        areset = 1'b0;

        // Simultaneous AW/W with explicit latency checks.
        tick();
        awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("t1_bvalid_exec",  32'(bvalid),  32'd0);
        checkOutput("t1_awready_exec", 32'(awready), 32'd0);
        checkOutput("t1_wready_exec",  32'(wready),  32'd0);
        tick();
        exp_regs[1] = 32'hDEADBEEF;
        checkOutput("t1_bvalid", 32'(bvalid), 32'd1);
        checkOutput("t1_bresp",  32'(bresp),  32'd0);
        checkRegs("t1");
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("t1_bvalid_done",  32'(bvalid),  32'd0);
        checkOutput("t1_awready_done", 32'(awready), 32'd1);
        applyRead(32'h4, rd_data, rd_resp);
        checkOutput("t1_rdata", rd_data, 32'hDEADBEEF);
        checkOutput("t1_rresp", 32'(rd_resp), 32'd0);

        // W arrives well before AW.
        awaddr = 32'h8; wdata = 32'h12345678; wstrb = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2_wready_wait%0d", i),  32'(wready),  32'd0);
            checkOutput($sformatf("t2_awready_wait%0d", i), 32'(awready), 32'd1);
            checkOutput($sformatf("t2_bvalid_wait%0d", i),  32'(bvalid),  32'd0);
            tick();
        end
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        exp_regs[2] = 32'h12345678;
        checkOutput("t2_bvalid", 32'(bvalid), 32'd1);
        checkOutput("t2_bresp",  32'(bresp),  32'd0);
        checkRegs("t2");
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("t2_bvalid_done", 32'(bvalid), 32'd0);
        tick();
        checkOutput("t2_single_resp", 32'(bvalid), 32'd0);

        // Partial strobe.
        applyWrite(32'hC, 32'hFFFFFFFF, 4'hF, wr_resp);
        checkOutput("t3_full_bresp", 32'(wr_resp), 32'd0);
        applyWrite(32'hC, 32'h0000A500, 4'b0010, wr_resp);
        exp_regs[3] = 32'hFFFFA5FF;
        checkOutput("t3_part_bresp", 32'(wr_resp), 32'd0);
        checkRegs("t3");

        // Zero strobe to a legal address, with low address bits set.
        applyWrite(32'h7, 32'h0BAD0BAD, 4'b0000, wr_resp);
        checkOutput("t3_zero_strb_bresp", 32'(wr_resp), 32'd0);
        checkRegs("t3z");

        // Out of range.
        applyWrite(32'h20, 32'h11111111, 4'hF, wr_resp);
        checkOutput("t4_oor_bresp", 32'(wr_resp), 32'b10);
        checkRegs("t4");
        applyRead(32'h24, rd_data, rd_resp);
        checkOutput("t4_oor_rdata", rd_data, 32'h0);
        checkOutput("t4_oor_rresp", 32'(rd_resp), 32'b10);
        applyRead(32'h1C, rd_data, rd_resp);
        checkOutput("t4_last_rdata", rd_data, 32'h0);
        checkOutput("t4_last_rresp", 32'(rd_resp), 32'd0);

        // Backpressure on both response channels.
        awaddr = 32'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        araddr = 32'h8;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        exp_regs[0] = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_bvalid%0d", i),  32'(bvalid),  32'd1);
            checkOutput($sformatf("t5_bresp%0d", i),   32'(bresp),   32'd0);
            checkOutput($sformatf("t5_rvalid%0d", i),  32'(rvalid),  32'd1);
            checkOutput($sformatf("t5_rresp%0d", i),   32'(rresp),   32'd0);
            checkOutput($sformatf("t5_rdata%0d", i),   rdata,        32'h12345678);
            checkOutput($sformatf("t5_awready%0d", i), 32'(awready), 32'd0);
            checkOutput($sformatf("t5_wready%0d", i),  32'(wready),  32'd0);
            checkOutput($sformatf("t5_arready%0d", i), 32'(arready), 32'd0);
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        checkOutput("t5_bvalid_done",  32'(bvalid),  32'd0);
        checkOutput("t5_rvalid_done",  32'(rvalid),  32'd0);
        checkOutput("t5_arready_done", 32'(arready), 32'd1);
        checkRegs("t5");

        // Read lands on the same edge as the write execute: old value returned.
        awaddr = 32'h4; wdata = 32'h55555555; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h4; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        exp_regs[1] = 32'h55555555;
        checkOutput("t6_collision_rdata", rdata, 32'hDEADBEEF);
        checkOutput("t6_collision_rvalid", 32'(rvalid), 32'd1);
        checkRegs("t6");
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // Reset while the write response is pending.
        awaddr = 32'h10; wdata = 32'h00000077; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        checkOutput("t7_bvalid_pending", 32'(bvalid), 32'd1);
        areset = 1'b1;
        #1;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 32'h0;
        checkOutput("t7_bvalid_async", 32'(bvalid), 32'd0);
        checkRegs("t7");
        #5;
        areset = 1'b0;
        tick();
        checkOutput("t7_awready", 32'(awready), 32'd1);
        checkOutput("t7_wready",  32'(wready),  32'd1);
        checkOutput("t7_arready", 32'(arready), 32'd1);
        checkOutput("t7_bvalid",  32'(bvalid),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
